// File: rtl/encoder_pkg.sv
// rtl/encoder_pkg.sv - shared constants and helpers for the decoder/encoder family
package encoder_pkg;

    localparam int RESET_IDX = 0;

    function automatic int clog2(input int value);
        int result;
        result = 0;
        while ((1 << result) < value) begin
            result = result + 1;
        end
        return result;
    endfunction

endpackage

// File: rtl/lowest_set_sel.sv
// rtl/lowest_set_sel.sv - combinational lowest-set-bit selector: index, found flag, one-hot
import encoder_pkg::*;

module lowest_set_sel #(
    parameter int N = 4,
    parameter int W = clog2(N)
) (
    input  logic [N-1:0] vec,
    output logic [W-1:0] idx,
    output logic         found,
    output logic [N-1:0] onehot
);

    // Scan from the top down so the lowest set bit is the last one written.
    always_comb begin
        idx    = '0;
        onehot = '0;
        found  = |vec;
        for (int i = N - 1; i >= 0; i--) begin
            if (vec[i]) begin
                idx    = W'(i);
                onehot = N'(1) << i;
            end
        end
    end

endmodule

// File: rtl/priority_encoder_stream.sv
// rtl/priority_encoder_stream.sv - sticky request collector emitting lowest index per handshake
import encoder_pkg::*;

module priority_encoder_stream #(
    parameter int N = 4,
    parameter int W = clog2(N)
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic [N-1:0] req,
    output logic         out_valid,
    output logic [W-1:0] out_idx,
    input  logic         out_ready,
    output logic [N-1:0] pending,
    output logic         merged,
    output logic         busy
);

    logic [N-1:0] eff;
    logic         load;
    logic [W-1:0] sel_idx;
    logic         sel_found;
    logic [N-1:0] sel_onehot;

    assign eff  = pending | req;
    assign load = ~out_valid | out_ready;
    assign busy = out_valid | (|pending);

    lowest_set_sel #(
        .N(N),
        .W(W)
    ) u_sel (
        .vec    (eff),
        .idx    (sel_idx),
        .found  (sel_found),
        .onehot (sel_onehot)
    );

    // A request matching the index being loaded is consumed; one matching a held,
    // unaccepted index lands in pending as a fresh request.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid <= 1'b0;
            out_idx   <= W'(RESET_IDX);
            pending   <= '0;
            merged    <= 1'b0;
        end else begin
            merged <= |(req & pending);
            if (load) begin
                if (sel_found) begin
                    out_valid <= 1'b1;
                    out_idx   <= sel_idx;
                    pending   <= eff & ~sel_onehot;
                end else begin
                    out_valid <= 1'b0;
                    pending   <= '0;
                end
            end else begin
                pending <= eff;
            end
        end
    end

endmodule

// File: tb/tb_priority_encoder_stream.sv
// tb/tb_priority_encoder_stream.sv - scoreboard bench for priority_encoder_stream
module tb_priority_encoder_stream;

    logic       clk;
    logic       rst_n;
    logic [3:0] req;
    logic       out_valid;
    logic [1:0] out_idx;
    logic       out_ready;
    logic [3:0] pending;
    logic       merged;
    logic       busy;

    int passed;
    int total;
    int sb[$];

    priority_encoder_stream #(.N(4)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req       (req),
        .out_valid (out_valid),
        .out_idx   (out_idx),
        .out_ready (out_ready),
        .pending   (pending),
        .merged    (merged),
        .busy      (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input int act, input int exp);
        total = total + 1;
        if (act == exp) passed = passed + 1;
        else $display("FAIL %s: got %0d expected %0d", name, act, exp);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check_idle(input string name);
        check({name, "_valid"},   int'(out_valid), 0);
        check({name, "_pending"}, int'(pending),   0);
        check({name, "_merged"},  int'(merged),    0);
        check({name, "_busy"},    int'(busy),      0);
    endtask

    // Each negedge with valid & ready is one acceptance at the coming edge.
    always @(negedge clk) begin
        if (rst_n && out_valid && out_ready) begin
            if (sb.size() == 0) begin
                check("unexpected_idx", int'(out_idx), -1);
            end else begin
                check("sb_idx", int'(out_idx), sb.pop_front());
            end
        end
    end

    initial begin
        #20000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        passed    = 0;
        total     = 0;
        rst_n     = 1'b0;
        req       = 4'b1111;
        out_ready = 1'b0;

        // 1: reset holds everything at zero despite requests
        repeat (3) step();
        check_idle("rst");
        check("rst_idx", int'(out_idx), 0);
        rst_n = 1'b1;
        req   = 4'b0000;
        repeat (2) step();
        check_idle("post_rst");
        check("post_rst_idx", int'(out_idx), 0);

        // 2: burst drain 0,1,3
        out_ready = 1'b1;
        req       = 4'b1011;
        sb.push_back(0); sb.push_back(1); sb.push_back(3);
        step();
        req = 4'b0000;
        check("burst_valid", int'(out_valid), 1);
        check("burst_idx0", int'(out_idx), 0);
        check("burst_pend0", int'(pending), 4'b1010);
        check("burst_merged", int'(merged), 0);
        step();
        check("burst_idx1", int'(out_idx), 1);
        step();
        check("burst_idx3", int'(out_idx), 3);
        check("burst_pend3", int'(pending), 0);
        step();
        check_idle("burst_end");

        // 3: backpressure keeps index 1 stable
        out_ready = 1'b0;
        req       = 4'b0110;
        sb.push_back(1); sb.push_back(2);
        step();
        req = 4'b0000;
        for (int i = 0; i < 3; i++) begin
            check("bp_idx", int'(out_idx), 1);
            check("bp_pend", int'(pending), 4'b0100);
            step();
        end
        out_ready = 1'b1;
        step();
        check("bp_idx2", int'(out_idx), 2);
        check("bp_valid2", int'(out_valid), 1);
        step();
        check_idle("bp_end");

        // 4: coalesce a request onto a pending bit
        out_ready = 1'b0;
        req       = 4'b0110;
        sb.push_back(1); sb.push_back(2);
        step();
        req = 4'b0100;
        step();
        req = 4'b0000;
        check("co_merged", int'(merged), 1);
        check("co_pend", int'(pending), 4'b0100);
        check("co_idx", int'(out_idx), 1);
        step();
        check("co_merged_clr", int'(merged), 0);
        out_ready = 1'b1;
        step();
        check("co_idx2", int'(out_idx), 2);
        step();
        check_idle("co_end");

        // 5: re-request of the held index becomes a new pending request
        out_ready = 1'b0;
        req       = 4'b1000;
        sb.push_back(3);
        step();
        check("rr_idx", int'(out_idx), 3);
        check("rr_pend0", int'(pending), 0);
        sb.push_back(3);
        step();
        req = 4'b0000;
        check("rr_pend", int'(pending), 4'b1000);
        check("rr_merged", int'(merged), 0);
        out_ready = 1'b1;
        step();
        check("rr_idx_again", int'(out_idx), 3);
        check("rr_valid_again", int'(out_valid), 1);
        check("rr_pend_clr", int'(pending), 0);
        step();
        check_idle("rr_end");

        // 6: asynchronous reset mid-operation
        out_ready = 1'b0;
        req       = 4'b1111;
        step();
        req = 4'b0000;
        check("mr_valid", int'(out_valid), 1);
        check("mr_pend", int'(pending), 4'b1110);
        #2;
        rst_n = 1'b0;
        sb.delete();
        #1;
        check_idle("mr_async");
        check("mr_idx", int'(out_idx), 0);
        step();
        rst_n     = 1'b1;
        out_ready = 1'b1;
        repeat (3) step();
        check_idle("mr_after");

        check("sb_empty", sb.size(), 0);
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
